// File: rtl/sound_i2s_out_if.sv
// Signal bundle for sound_i2s_out: mix inputs, volume/mute controls and I2S outputs.
interface sound_i2s_out_if;
  // No valid/ready: samples and controls are level inputs sampled every clk;
  // frame_strobe marks the single clk on which a new L/R pair is latched.
  logic signed [15:0] sample_l;
  logic signed [15:0] sample_r;
  logic signed [15:0] sample_opl_l;
  logic signed [15:0] sample_opl_r;
  logic [4:0]         vol_l;
  logic [4:0]         vol_r;
  logic               mute;
  logic               i2s_bclk;
  logic               i2s_lrck;
  logic               i2s_sdata;
  logic               frame_strobe;
  logic               clip;

  modport master (
    output sample_l, sample_r, sample_opl_l, sample_opl_r, vol_l, vol_r, mute,
    input  i2s_bclk, i2s_lrck, i2s_sdata, frame_strobe, clip
  );

  modport slave (
    input  sample_l, sample_r, sample_opl_l, sample_opl_r, vol_l, vol_r, mute,
    output i2s_bclk, i2s_lrck, i2s_sdata, frame_strobe, clip
  );
endinterface

// File: rtl/sound_i2s_out.sv
// Saturating DSP+OPL mix, master volume/mute and Philips I2S serialiser.
// Optional DC-blocking high-pass per channel when SOUND_I2S_DCBLOCK_EN is defined.
module sound_i2s_out #(
  parameter int BCLK_DIV  = 8,
  parameter int SLOT_BITS = 16
) (
  input logic            clk,
  input logic            rst_n,
  sound_i2s_out_if.slave bus
);
  localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int FW = 2 * SLOT_BITS;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);

  function automatic logic [15:0] vol_scale(input logic signed [15:0] x, input logic [4:0] vol);
    logic signed [15:0] r;
    logic [3:0]         sh;
    sh = ~vol[4:1];
    r  = x >>> sh;
    return (vol == 5'd0) ? 16'h0000 : r;
  endfunction

  logic [DW-1:0]      div_cnt_q, div_cnt_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic               started_q;
  logic               bclk_q, lrck_q, sdata_q, strobe_q, clip_q;
  logic [FW-1:0]      sreg_q;
  logic signed [15:0] s1_l_q, s1_r_q, s2_l_q, s2_r_q;
  logic signed [15:0] s1_l_d, s1_r_d;
  logic [16:0]        sum_l, sum_r;
  logic               sat_l, sat_r, fall, latch, dc_sat;
  logic [15:0]        word_l, word_r;

  always_comb begin
    sum_l  = {bus.sample_l[15], bus.sample_l} + {bus.sample_opl_l[15], bus.sample_opl_l};
    sum_r  = {bus.sample_r[15], bus.sample_r} + {bus.sample_opl_r[15], bus.sample_opl_r};
    sat_l  = sum_l[16] ^ sum_l[15];
    sat_r  = sum_r[16] ^ sum_r[15];
    s1_l_d = sat_l ? (sum_l[16] ? 16'sh8000 : 16'sh7FFF) : sum_l[15:0];
    s1_r_d = sat_r ? (sum_r[16] ? 16'sh8000 : 16'sh7FFF) : sum_r[15:0];
  end

  // A BCLK falling edge coincides with the divider wrapping to 0.
  always_comb begin
    fall      = (div_cnt_q == DIV_LAST);
    div_cnt_d = fall ? '0 : div_cnt_q + DW'(1);
    bit_cnt_d = started_q ? bit_cnt_q + 5'd1 : 5'd0;
    latch     = fall && started_q && (bit_cnt_q == 5'd31);
  end

`ifdef SOUND_I2S_DCBLOCK_EN
  logic signed [15:0] xp_l_q, xp_r_q, yp_l_q, yp_r_q;
  logic signed [15:0] y_l, y_r;
  logic               dsat_l, dsat_r;

  function automatic logic [16:0] dc_step(input logic signed [15:0] x, xp, yp);
    logic signed [17:0] acc;
    acc = 18'(x) - 18'(xp) + 18'(yp) - 18'(yp >>> 8);
    if (acc > 18'sd32767)       return {1'b1, 16'h7FFF};
    else if (acc < -18'sd32768) return {1'b1, 16'h8000};
    else                        return {1'b0, acc[15:0]};
  endfunction

  always_comb begin
    {dsat_l, y_l} = dc_step(s2_l_q, xp_l_q, yp_l_q);
    {dsat_r, y_r} = dc_step(s2_r_q, xp_r_q, yp_r_q);
    dc_sat        = dsat_l | dsat_r;
    word_l        = bus.mute ? 16'h0000 : y_l;
    word_r        = bus.mute ? 16'h0000 : y_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xp_l_q <= '0;
      xp_r_q <= '0;
      yp_l_q <= '0;
      yp_r_q <= '0;
    end else if (latch) begin
      xp_l_q <= s2_l_q;
      xp_r_q <= s2_r_q;
      yp_l_q <= y_l;
      yp_r_q <= y_r;
    end
  end
`else
  always_comb begin
    dc_sat = 1'b0;
    word_l = bus.mute ? 16'h0000 : s2_l_q;
    word_r = bus.mute ? 16'h0000 : s2_r_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_l_q    <= '0;
      s1_r_q    <= '0;
      s2_l_q    <= '0;
      s2_r_q    <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      started_q <= 1'b0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      strobe_q  <= 1'b0;
      clip_q    <= 1'b0;
      sreg_q    <= '0;
    end else begin
      s1_l_q    <= s1_l_d;
      s1_r_q    <= s1_r_d;
      s2_l_q    <= vol_scale(s1_l_q, bus.vol_l);
      s2_r_q    <= vol_scale(s1_r_q, bus.vol_r);
      div_cnt_q <= div_cnt_d;
      bclk_q    <= (div_cnt_d >= DIV_HALF);
      strobe_q  <= latch;
      clip_q    <= clip_q | sat_l | sat_r | (latch & dc_sat);
      if (fall) begin
        // Bit 31 of the shift register is the previous right LSB when a new pair loads.
        started_q <= 1'b1;
        bit_cnt_q <= bit_cnt_d;
        lrck_q    <= bit_cnt_d[4];
        sdata_q   <= sreg_q[FW-1];
        sreg_q    <= latch ? {word_l, word_r} : {sreg_q[FW-2:0], 1'b0};
      end
    end
  end

  assign bus.i2s_bclk     = bclk_q;
  assign bus.i2s_lrck     = lrck_q;
  assign bus.i2s_sdata    = sdata_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.clip         = clip_q;
endmodule

// File: tb/tb_sound_i2s_out.sv
// Randomised bench for sound_i2s_out: I2S stream decoder checked against an arithmetic frame model.
module tb_sound_i2s_out;
  localparam int NF    = 16;
  localparam int K_END = 268 + 256 * NF + 10;

  logic clk = 1'b0;
  logic rst_n;
  sound_i2s_out_if bus ();

  sound_i2s_out #(.BCLK_DIV(8), .SLOT_BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int mix_sum(input logic [15:0] a, input logic [15:0] b);
    return int'($signed(a)) + int'($signed(b));
  endfunction

  function automatic logic mix_sat(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = mix_sum(a, b);
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic int mix_word(input logic [15:0] a, input logic [15:0] b, input logic [4:0] vol);
    int s;
    s = mix_sum(a, b);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (vol == 5'd0) return 0;
    return s >>> (15 - int'(vol) / 2);
  endfunction

  int dc_xp[2], dc_yp[2];

  // Filter step on signed integers; returns the saturated output, flags saturation.
  function automatic int dc_filter(input int ch, input int x, output logic sat);
    int y;
    y   = x - dc_xp[ch] + dc_yp[ch] - (dc_yp[ch] >>> 8);
    sat = 1'b0;
    if (y > 32767)  begin y = 32767;  sat = 1'b1; end
    if (y < -32768) begin y = -32768; sat = 1'b1; end
    dc_xp[ch] = x;
    dc_yp[ch] = y;
    return y;
  endfunction

  task automatic set_frame(input int f);
    bus.sample_l = '0; bus.sample_r = '0; bus.sample_opl_l = '0; bus.sample_opl_r = '0;
    bus.vol_l = 5'd31; bus.vol_r = 5'd31; bus.mute = 1'b0;
    case (f)
      0: bus.sample_l = 16'hA5C3;
      1: begin bus.sample_r = 16'h4000; bus.vol_r = 5'd23; end
      2: begin bus.sample_r = 16'h4000; bus.vol_r = 5'd0; end
      3: begin bus.sample_r = 16'h4000; bus.vol_r = 5'd1; end
      4: begin bus.sample_l = 16'h7000; bus.sample_opl_l = 16'h7000; end
      5: begin bus.sample_l = 16'h8000; bus.sample_opl_l = 16'h8000; bus.sample_r = 16'h1234; end
      6: begin bus.sample_l = 16'h2222; bus.sample_r = 16'h3333; bus.mute = 1'b1; end
      7: begin bus.sample_l = 16'h2222; bus.sample_r = 16'h3333; end
      default: begin
        bus.sample_l     = 16'($urandom_range(0, 16'hFFFF));
        bus.sample_r     = 16'($urandom_range(0, 16'hFFFF));
        bus.sample_opl_l = 16'($urandom_range(0, 16'hFFFF));
        bus.sample_opl_r = 16'($urandom_range(0, 16'hFFFF));
        bus.vol_l        = 5'($urandom_range(0, 31));
        bus.vol_r        = 5'($urandom_range(0, 31));
        bus.mute         = ($urandom_range(0, 3) == 0);
      end
    endcase
  endtask

  initial begin
    int          k, f, n, wl, wr, n_pairs;
    logic        clip_m, latch_now, lrck_exp, bclk_prev, lrck_prev, sat_x;
    logic [15:0] hist, left_w;
    logic [31:0] pair;

    k = 0; f = 0; n_pairs = 0;
    clip_m = 1'b0; bclk_prev = 1'b0; lrck_prev = 1'b0; hist = '0; left_w = '0;
    dc_xp[0] = 0; dc_xp[1] = 0; dc_yp[0] = 0; dc_yp[1] = 0;
    bus.sample_l = '0; bus.sample_r = '0; bus.sample_opl_l = '0; bus.sample_opl_r = '0;
    bus.vol_l = 5'd31; bus.vol_r = 5'd31; bus.mute = 1'b0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_bclk", 32'(bus.i2s_bclk), 0);
    check("rst_lrck", 32'(bus.i2s_lrck), 0);
    check("rst_sdata", 32'(bus.i2s_sdata), 0);
    check("rst_strobe", 32'(bus.frame_strobe), 0);
    check("rst_clip", 32'(bus.clip), 0);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);

    while (k < K_END) begin
      @(negedge clk);
      k++;
      if (mix_sat(bus.sample_l, bus.sample_opl_l) || mix_sat(bus.sample_r, bus.sample_opl_r))
        clip_m = 1'b1;

      latch_now = (k >= 264) && ((k % 256) == 8);
      if (latch_now) begin
        wl = mix_word(bus.sample_l, bus.sample_opl_l, bus.vol_l);
        wr = mix_word(bus.sample_r, bus.sample_opl_r, bus.vol_r);
`ifdef SOUND_I2S_DCBLOCK_EN
        wl = dc_filter(0, wl, sat_x);
        if (sat_x) clip_m = 1'b1;
        wr = dc_filter(1, wr, sat_x);
        if (sat_x) clip_m = 1'b1;
`else
        sat_x = 1'b0;
`endif
        if (bus.mute) begin wl = 0; wr = 0; end
        exp_q.push_back({wl[15:0], wr[15:0]});
      end

      n = k / 8;
      lrck_exp = (n == 0) ? 1'b0 : (((n - 1) % 32) >= 16);
      check("strobe", 32'(bus.frame_strobe), 32'(latch_now));
      check("bclk", 32'(bus.i2s_bclk), 32'((k % 8) >= 4));
      check("lrck", 32'(bus.i2s_lrck), 32'(lrck_exp));
      check("clip", 32'(bus.clip), 32'(clip_m));

      // Philips decode: the bit sampled when LRCK toggles closes the previous word.
      if (bus.i2s_bclk && !bclk_prev) begin
        hist = {hist[14:0], bus.i2s_sdata};
        if (bus.i2s_lrck && !lrck_prev) left_w = hist;
        if (!bus.i2s_lrck && lrck_prev) begin
          n_pairs++;
          if (exp_q.size() == 0) begin
            check("pair_unexpected", {left_w, hist}, 32'hxxxx_xxxx);
          end else begin
            pair = exp_q.pop_front();
            check("left_word", 32'(left_w), 32'(pair[31:16]));
            check("right_word", 32'(hist), 32'(pair[15:0]));
          end
        end
        lrck_prev = bus.i2s_lrck;
      end
      bclk_prev = bus.i2s_bclk;

      if ((k % 256) == 100) begin
        set_frame(f);
        f++;
      end
    end

    check("pairs_decoded", 32'(n_pairs), 32'(NF + 1));
    check("pending_frames", 32'(exp_q.size()), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sound_i2s_out.md
Name: sound_i2s_out

Overview:
- Downstream stage of the sound block; runs entirely in the audio clock domain.
- Takes the DSP/CMS mix (already crossed into this domain) and the OPL samples (already volume-scaled by midi volume).
- Sums them with saturation, applies master volume and mute, and serialises the stereo result as a standard Philips I2S stream with generated BCLK/LRCK.

Parameters:
BCLK_DIV, 8, clk cycles per BCLK period; even, >=2.
SLOT_BITS, 16, bits per channel slot; frame = 2*SLOT_BITS BCLKs; fixed 16 in this revision.

Ports:
clk  input  1  audio clock (clk_audio domain)
rst_n  input  1  asynchronous active-low reset
sample_l  input  16  signed DSP/CMS left sample
sample_r  input  16  signed DSP/CMS right sample
sample_opl_l  input  16  signed OPL left sample
sample_opl_r  input  16  signed OPL right sample
vol_l  input  5  master volume left (31 = 0 dB, 0 = silent)
vol_r  input  5  master volume right
mute  input  1  level; forces output words to 0 from next frame latch
i2s_bclk  output  1  bit clock
i2s_lrck  output  1  word select, 0 = left, 1 = right
i2s_sdata  output  1  serial data, MSB first
frame_strobe  output  1  1-clk pulse when a new L/R pair is latched
clip  output  1  sticky saturation flag; cleared only by reset

Behaviour:
- Reset is asynchronous; all state clears while rst_n = 0.
  - Reset values: i2s_bclk = 0, i2s_lrck = 0, i2s_sdata = 0, frame_strobe = 0, clip = 0.
  - Reset clears the divider, bit counter, shift register, frame latch and all pipeline registers.
- Reset mid-frame aborts the frame. After release the first BCLK falling edge starts slot 0 of a left half, and silence (0) is transmitted until the first latch.
- Mix pipeline runs every clk, independent of BCLK:
  - Stage 1: 17-bit signed sum = sample_x + sample_opl_x. Saturate to 0x7FFF / 0x8000. Any saturation sets clip.
  - Stage 2: vol == 0 -> 0; otherwise arithmetic shift right by (~vol[4:1]), a 4-bit amount. vol 31 or 30 -> shift 0; vol 1 -> shift 15; vol[0] is ignored.
  - Input-to-stage-2 latency: 2 clk.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - i2s_bclk = 0 while div_cnt < BCLK_DIV/2, else 1, registered.
  - A BCLK falling edge occurs on each div_cnt wrap to 0.
- Bit counter:
  - bit_cnt (5 bits) increments on each falling edge and wraps 31 -> 0.
  - i2s_lrck = 0 for bit_cnt 0..15 and 1 for bit_cnt 16..31.
  - i2s_lrck and i2s_sdata both change only on falling edges.
- Frame latch:
  - On the falling edge where bit_cnt wraps 31 -> 0, the stage-2 L and R values are latched (0 if mute = 1).
  - frame_strobe pulses for exactly that clk.
  - Changes to inputs or mute between latches do not affect the frame in flight.
- Slot mapping (Philips one-BCLK delay):
  - slot 0 = LSB of previous right word.
  - slots 1..16 = left bits 15..0.
  - slots 17..31 = right bits 15..1.
  - The right LSB goes out in slot 0 of the next frame.
- Timing: sample rate = f_clk / (BCLK_DIV*32). A latched value first appears on i2s_sdata one BCLK after the latch.
- Simultaneous events: a saturation and a latch in the same clk means the latched value is the saturated value.

Optional Feature:
Macro SOUND_I2S_DCBLOCK_EN.
- Defined: a DC-blocking high-pass is inserted after stage 2, per channel.
  - y = x - x_prev + y_prev - (y_prev >>> 8), evaluated in an 18-bit accumulator and saturated to 16 bits; saturation here also sets clip.
  - Updated once per frame latch, not per clk, so latency and timing are otherwise unchanged.
  - x_prev and y_prev reset to 0.
- Undefined: no filter; stage-2 output is latched directly.

Test Plan:
- Reset, then hold rst_n = 1 with BCLK_DIV = 8 -> i2s_bclk period 8 clk; i2s_lrck period 256 clk; frame_strobe once per 256 clk.
- sample_l = 0xA5C3, all other inputs 0, vol_l = 31 -> left slots 1..16 carry 1010_0101_1100_0011 MSB first; right slots all 0.
- sample_l = 0x7000 and sample_opl_l = 0x7000 -> left word 0x7FFF and clip = 1 (stays 1).
- sample_l = 0x8000 and sample_opl_l = 0x8000 -> left word 0x8000 and clip = 1 (stays 1).
- sample_r = 0x4000, vol_r = 23 (shift 4) -> right word 0x0400.
  - vol_r = 0 -> right word 0x0000.
  - vol_r = 1 -> right word 0x0000 (0x4000 >>> 15).
- mute asserted mid-frame -> current frame unchanged; next frame both words 0; deassert -> data resumes at the following latch.
- With SOUND_I2S_DCBLOCK_EN, constant input 0x1000 -> first latched left word 0x1000, then decays monotonically toward 0 over successive frames.
